// File: rtl/elev_pkg.sv
// Shared types and helpers for the four-floor elevator sequencer.
package elev_pkg;

    localparam int NUM_FLOORS = 4;

    typedef logic [1:0] floor_t;

    typedef enum logic [1:0] {
        IDLE,
        MOVE_UP,
        MOVE_DOWN,
        DOOR_OPEN
    } state_t;

    // True when any call is latched strictly above the given floor.
    function automatic logic any_above(input logic [NUM_FLOORS-1:0] pend, input floor_t fl);
        logic r_hit;
        r_hit = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if ((i > int'(fl)) && pend[i]) r_hit = 1'b1;
        end
        return r_hit;
    endfunction

    // True when any call is latched strictly below the given floor.
    function automatic logic any_below(input logic [NUM_FLOORS-1:0] pend, input floor_t fl);
        logic r_hit;
        r_hit = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if ((i < int'(fl)) && pend[i]) r_hit = 1'b1;
        end
        return r_hit;
    endfunction

endpackage

// File: rtl/elevator_ctrl_timer.sv
// Loadable down-counter shared by the travel and door phases.
// The count stops at zero; o_done is high while the count is zero, so a
// load value of N-1 yields an expiry exactly N cycles after the load edge.
module elev_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    // Load has priority; otherwise count down and hold at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/elevator_ctrl.sv
// Four-floor elevator sequencer: latches floor calls, moves the car with a
// keep-direction (SCAN) policy and times the door dwell.
// Optional feature macro: ELEV_DOOR_HOLD_EN adds the door_hold input, which
// keeps the door open while asserted.
module elevator_ctrl
    import elev_pkg::*;
#(
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
`ifdef ELEV_DOOR_HOLD_EN
    input  logic       door_hold,
`endif
    output logic [1:0] floor_sel,
    output logic       door,
    output logic       moving,
    output logic       dir_up,
    output logic [3:0] pending
);

    localparam int MAX_CYC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TW      = $clog2(MAX_CYC);
    // Timer is loaded with N-1 so it expires N cycles after the load edge.
    localparam logic [TW-1:0] TRAVEL_LD = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0] DOOR_LD   = TW'(DOOR_CYCLES - 1);

    state_t                  r_state;
    floor_t                  r_floor;
    logic                    r_door;
    logic                    r_moving;
    logic                    r_dir_up;
    logic [NUM_FLOORS-1:0]   r_pending;

    logic                    w_hold;
    logic                    w_done;
    floor_t                  w_step_floor;
    logic                    w_above;
    logic                    w_below;
    logic                    w_arr_hit;
    logic                    w_arr_cont;
    logic                    w_restart;
    logic [NUM_FLOORS-1:0]   w_clr;
    logic                    w_load;
    logic [TW-1:0]           w_load_val;

`ifdef ELEV_DOOR_HOLD_EN
    assign w_hold = door_hold;
`else
    assign w_hold = 1'b0;
`endif

    // Floor decode: neighbours of the current floor and the arrival decision.
    always_comb begin
        w_step_floor = (r_state == MOVE_DOWN) ? (r_floor - 2'd1) : (r_floor + 2'd1);
        w_above      = any_above(r_pending, r_floor);
        w_below      = any_below(r_pending, r_floor);
        w_arr_hit    = r_pending[w_step_floor];
        w_arr_cont   = (r_state == MOVE_UP) ? any_above(r_pending, w_step_floor)
                                            : any_below(r_pending, w_step_floor);
        w_restart    = req[r_floor] | w_hold;
    end

    // Call clearing and timer load control for the shared timer.
    always_comb begin
        w_clr      = '0;
        w_load     = 1'b0;
        w_load_val = TRAVEL_LD;
        case (r_state)
            IDLE: begin
                if (r_pending[r_floor]) begin
                    w_clr[r_floor] = 1'b1;
                    w_load         = 1'b1;
                    w_load_val     = DOOR_LD;
                end else if (w_above || w_below) begin
                    w_load = 1'b1;
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                if (w_done) begin
                    if (w_arr_hit) begin
                        w_clr[w_step_floor] = 1'b1;
                        w_load              = 1'b1;
                        w_load_val          = DOOR_LD;
                    end else if (w_arr_cont) begin
                        w_load = 1'b1;
                    end
                end
            end
            DOOR_OPEN: begin
                // Calls for the floor being served are absorbed, not latched.
                w_clr[r_floor] = 1'b1;
                if (w_restart) begin
                    w_load     = 1'b1;
                    w_load_val = DOOR_LD;
                end
            end
            default: ;
        endcase
    end

    elev_timer #(
        .W (TW)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_done     (w_done)
    );

    // Sequencer state, floor, direction, door and call latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_floor   <= '0;
            r_door    <= 1'b0;
            r_moving  <= 1'b0;
            r_dir_up  <= 1'b1;
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending | req) & ~w_clr;
            case (r_state)
                IDLE: begin
                    if (r_pending[r_floor]) begin
                        r_state <= DOOR_OPEN;
                        r_door  <= 1'b1;
                    end else if (w_above && (r_dir_up || !w_below)) begin
                        r_state  <= MOVE_UP;
                        r_moving <= 1'b1;
                        r_dir_up <= 1'b1;
                    end else if (w_below) begin
                        r_state  <= MOVE_DOWN;
                        r_moving <= 1'b1;
                        r_dir_up <= 1'b0;
                    end
                end
                MOVE_UP, MOVE_DOWN: begin
                    if (w_done) begin
                        r_floor <= w_step_floor;
                        if (w_arr_hit) begin
                            r_state  <= DOOR_OPEN;
                            r_door   <= 1'b1;
                            r_moving <= 1'b0;
                        end else if (!w_arr_cont) begin
                            r_state  <= IDLE;
                            r_moving <= 1'b0;
                        end
                    end
                end
                DOOR_OPEN: begin
                    if (!w_restart && w_done) begin
                        r_state <= IDLE;
                        r_door  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign floor_sel = r_floor;
    assign door      = r_door;
    assign moving    = r_moving;
    assign dir_up    = r_dir_up;
    assign pending   = r_pending;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Self-checking bench for elevator_ctrl: directed scenarios followed by
// random call traffic, all compared cycle by cycle against a reference model
// that tracks the car as floor number, direction and cycles-to-next-event.
module tb_elevator_ctrl;

    localparam int TRAV  = 8;
    localparam int DOORC = 6;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       hold;
    logic [1:0] floor_sel;
    logic       door;
    logic       moving;
    logic       dir_up;
    logic [3:0] pending;

    int vectors     = 0;
    int miscompares = 0;

    // reference model
    logic [3:0] m_pend;
    int         m_floor;
    bit         m_door;
    bit         m_mov;
    bit         m_dir;
    int         m_left;

    logic [3:0] seen_doors;
    bit         saw_down;

    elevator_ctrl #(
        .TRAVEL_CYCLES (TRAV),
        .DOOR_CYCLES   (DOORC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
`ifdef ELEV_DOOR_HOLD_EN
        .door_hold (hold),
`endif
        .floor_sel (floor_sel),
        .door      (door),
        .moving    (moving),
        .dir_up    (dir_up),
        .pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit m_above(input logic [3:0] p, input int f);
        for (int i = f + 1; i < 4; i++) if (p[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_below(input logic [3:0] p, input int f);
        for (int i = 0; i < f; i++) if (p[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_pend  = 4'b0;
        m_floor = 0;
        m_door  = 1'b0;
        m_mov   = 1'b0;
        m_dir   = 1'b1;
        m_left  = 0;
    endtask

    // One clock edge of the car, computed from pre-edge state.
    task automatic model_edge(input logic [3:0] r, input logic h);
        logic [3:0] np;
        np = m_pend | r;
        if (m_door) begin
            np[m_floor] = 1'b0;
            if (r[m_floor] || h) begin
                m_left = DOORC;
            end else begin
                m_left--;
                if (m_left == 0) m_door = 1'b0;
            end
        end else if (m_mov) begin
            m_left--;
            if (m_left == 0) begin
                m_floor = m_dir ? m_floor + 1 : m_floor - 1;
                if (m_pend[m_floor]) begin
                    np[m_floor] = 1'b0;
                    m_door = 1'b1;
                    m_mov  = 1'b0;
                    m_left = DOORC;
                end else if (m_dir ? m_above(m_pend, m_floor) : m_below(m_pend, m_floor)) begin
                    m_left = TRAV;
                end else begin
                    m_mov = 1'b0;
                end
            end
        end else begin
            if (m_pend[m_floor]) begin
                np[m_floor] = 1'b0;
                m_door = 1'b1;
                m_left = DOORC;
            end else if (m_above(m_pend, m_floor) && (m_dir || !m_below(m_pend, m_floor))) begin
                m_mov = 1'b1; m_dir = 1'b1; m_left = TRAV;
            end else if (m_below(m_pend, m_floor)) begin
                m_mov = 1'b1; m_dir = 1'b0; m_left = TRAV;
            end
        end
        m_pend = np;
    endtask

    task automatic expect_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [1:0] ef;
        ef = 2'(m_floor);
        vectors++;
        assert (floor_sel === ef) else begin
            miscompares++; $error("FAIL floor_sel observed=%0d expected=%0d", floor_sel, ef);
        end
        vectors++;
        assert (door === m_door) else begin
            miscompares++; $error("FAIL door observed=%0b expected=%0b", door, m_door);
        end
        vectors++;
        assert (moving === m_mov) else begin
            miscompares++; $error("FAIL moving observed=%0b expected=%0b", moving, m_mov);
        end
        vectors++;
        assert (dir_up === m_dir) else begin
            miscompares++; $error("FAIL dir_up observed=%0b expected=%0b", dir_up, m_dir);
        end
        vectors++;
        assert (pending === m_pend) else begin
            miscompares++; $error("FAIL pending observed=%b expected=%b", pending, m_pend);
        end
        vectors++;
        assert ((door & moving) === 1'b0) else begin
            miscompares++; $error("FAIL door_while_moving observed=%0b expected=0", door & moving);
        end
    endtask

    // Drive inputs, take one edge, then compare at the falling edge.
    task automatic cyc(input logic [3:0] r, input logic h);
        req  = r;
        hold = h;
        @(posedge clk);
        model_edge(r, h);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        req  = 4'b0;
        hold = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_until_idle(input int budget, input string tag);
        int n;
        n = 0;
        seen_doors = 4'b0;
        saw_down   = 1'b0;
        while (!(pending == 4'b0 && !moving && !door) && n < budget) begin
            cyc(4'b0, 1'b0);
            if (door === 1'b1) seen_doors[floor_sel] = 1'b1;
            if (dir_up === 1'b0) saw_down = 1'b1;
            n++;
        end
        expect_int({tag, "_timeout"}, int'(n < budget), 1);
    endtask

    task automatic wait_floor(input int f, input int budget, input string tag);
        int n;
        n = 0;
        while (int'(floor_sel) != f && n < budget) begin
            cyc(4'b0, 1'b0);
            n++;
        end
        expect_int({tag, "_timeout"}, int'(n < budget), 1);
    endtask

    task automatic wait_door(input int budget, input string tag);
        int n;
        n = 0;
        while (door !== 1'b1 && n < budget) begin
            cyc(4'b0, 1'b0);
            n++;
        end
        expect_int({tag, "_timeout"}, int'(n < budget), 1);
    endtask

    task automatic count_door(output int n);
        n = 0;
        while (door === 1'b1 && n < 40) begin
            n++;
            cyc(4'b0, 1'b0);
        end
    endtask

    initial begin
        int n;
        logic [3:0] r;
        logic       h;
        rst_n = 1'b0;
        req   = 4'b0;
        hold  = 1'b0;
        model_reset();
        do_reset();
        expect_int("rst_floor",   int'(floor_sel), 0);
        expect_int("rst_dir_up",  int'(dir_up),    1);
        expect_int("rst_pending", int'(pending),   0);

        // call at the current floor: latch, open next edge, dwell
        cyc(4'b0001, 1'b0);
        expect_int("s1_latched", int'(pending), 1);
        cyc(4'b0000, 1'b0);
        expect_int("s1_door_open", int'(door), 1);
        count_door(n);
        expect_int("s1_dwell", n, DOORC);
        run_until_idle(50, "s1");

        // call to the top floor
        cyc(4'b1000, 1'b0);
        run_until_idle(200, "s2");
        expect_int("s2_doors", int'(seen_doors), 4'b1000);
        expect_int("s2_floor", int'(floor_sel), 3);

        // two calls up: stop at 1, continue to 3 without reversing
        do_reset();
        cyc(4'b1010, 1'b0);
        run_until_idle(200, "s3");
        expect_int("s3_doors", int'(seen_doors), 4'b1010);
        expect_int("s3_no_reverse", int'(saw_down), 0);
        expect_int("s3_floor", int'(floor_sel), 3);

        // call below while travelling up: finish upward first
        do_reset();
        cyc(4'b1000, 1'b0);
        wait_floor(2, 100, "s4_reach2");
        cyc(4'b0001, 1'b0);
        run_until_idle(300, "s4");
        expect_int("s4_doors", int'(seen_doors), 4'b1001);
        expect_int("s4_floor", int'(floor_sel), 0);
        expect_int("s4_dir_up", int'(dir_up), 0);

        // door restart from a same-floor call on cycle 4
        do_reset();
        cyc(4'b0010, 1'b0);
        wait_door(100, "s5_open");
        for (int i = 0; i < 3; i++) cyc(4'b0, 1'b0);
        cyc(4'b0010, 1'b0);
        expect_int("s5_not_latched", int'(pending), 0);
        count_door(n);
        expect_int("s5_dwell_after_pulse", n, DOORC);
`ifdef ELEV_DOOR_HOLD_EN
        cyc(4'b0010, 1'b0);
        wait_door(50, "s5h_open");
        for (int i = 0; i < 20; i++) cyc(4'b0, 1'b1);
        expect_int("s5h_still_open", int'(door), 1);
        count_door(n);
        expect_int("s5h_dwell_after_hold", n, DOORC);
`endif
        run_until_idle(50, "s5");

        // asynchronous reset in the middle of a downward move
        do_reset();
        cyc(4'b1000, 1'b0);
        run_until_idle(200, "s6_up");
        cyc(4'b0001, 1'b0);
        wait_floor(2, 100, "s6_reach2");
        expect_int("s6_moving", int'(moving), 1);
        expect_int("s6_down", int'(dir_up), 0);
        #2 rst_n = 1'b0;
        #1;
        expect_int("s6_async_floor",   int'(floor_sel), 0);
        expect_int("s6_async_moving",  int'(moving),    0);
        expect_int("s6_async_pending", int'(pending),   0);
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // random call traffic
        for (int i = 0; i < 800; i++) begin
            r = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
`ifdef ELEV_DOOR_HOLD_EN
            h = ($urandom_range(0, 9) == 0);
`else
            h = 1'b0;
`endif
            cyc(r, h);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
